// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: sync-FIFO read master with 2-entry skid buffer re-presenting data as a valid/ready stream (optional FIFO_RD_PARITY_EN adds m_parity)
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count,
`ifdef FIFO_RD_PARITY_EN
  output logic                  m_parity,
`endif
  output logic                  busy
);
  logic [1:0] occ, lvl, wi;
  logic inflight, pop;
  logic [DATA_WIDTH-1:0] d0, d1;
  assign m_valid = occ != 2'd0;
  assign m_data  = d0;
  assign busy    = m_valid || inflight;
  // level after this edge's pop, tail slot for the in-flight word, and the read request
  always_comb begin
    pop       = m_valid && m_ready;
    lvl       = occ + {1'b0, inflight} - {1'b0, pop};
    wi        = occ - {1'b0, pop};
    fifo_r_en = rst_n && en && !flush && !fifo_empty && !lvl[1];
  end
  // skid buffer: head shifts on pop, in-flight word lands in the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= '0;
      inflight   <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      beat_count <= '0;
    end else begin
      beat_count <= beat_count + CNT_WIDTH'(pop);
      inflight   <= fifo_r_en;
      occ        <= flush ? 2'd0 : lvl;
      d0         <= (inflight && wi == 2'd0) ? fifo_data_out : pop ? d1 : d0;
      d1         <= (inflight && wi == 2'd1) ? fifo_data_out : d1;
    end
  end
`ifdef FIFO_RD_PARITY_EN
  logic p0, p1;
  assign m_parity = p0;
  // per-entry parity computed at capture, moving with its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      p0 <= (inflight && wi == 2'd0) ? ^fifo_data_out : pop ? p1 : p0;
      p1 <= (inflight && wi == 2'd1) ? ^fifo_data_out : p1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed checks of fifo_rd_stream against a queue-based stream model
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, flush = 1'b0, m_ready = 1'b0, fifo_empty = 1'b1;
  logic fifo_r_en, m_valid, busy;
  logic [DW-1:0] fifo_data_out = '0, m_data;
  logic [CW-1:0] beat_count;
`ifdef FIFO_RD_PARITY_EN
  logic m_parity;
`endif
  always #5 clk = ~clk;
  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .fifo_r_en(fifo_r_en), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .beat_count(beat_count),
`ifdef FIFO_RD_PARITY_EN
    .m_parity(m_parity),
`endif
    .busy(busy)
  );
  typedef struct {logic [DW-1:0] d; int e;} ent_t;
  ent_t pend[$];
  logic [DW-1:0] mem[$], got[$], wq[$];
  int edges = 0, beats = 0, n_chk = 0, n_fail = 0, cyc = 0;
  int first_ren, first_val, ren_cnt, last_pop, gaps;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // one clock: drive inputs, compare DUT against the model, then advance model and FIFO stub
  task automatic cycle(input logic e, input logic r, input logic f, input logic w, input logic [DW-1:0] wd);
    logic xv, xp, xr;
    @(negedge clk);
    en = e; m_ready = r; flush = f;
    #2;
    xv = rst_n && pend.size() > 0 && pend[0].e < edges;
    xp = xv && r;
    xr = rst_n && e && !f && mem.size() > 0 && (pend.size() - int'(xp)) < 2;
    chk("m_valid", m_valid, xv);
    chk("fifo_r_en", fifo_r_en, xr);
    chk("busy", busy, rst_n && pend.size() > 0);
    chk("beat_count", beat_count, beats % 65536);
    if (xv) begin
      chk("m_data", m_data, pend[0].d);
`ifdef FIFO_RD_PARITY_EN
      chk("m_parity", m_parity, ^pend[0].d);
`endif
    end
    if (fifo_r_en) ren_cnt++;
    if (fifo_r_en && first_ren < 0) first_ren = cyc;
    if (m_valid && first_val < 0) first_val = cyc;
    if (xp) begin
      if (last_pop >= 0 && cyc != last_pop + 1) gaps++;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    edges++;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      beats = 0;
    end else begin
      if (xp) begin
        got.push_back(pend[0].d);
        void'(pend.pop_front());
        beats++;
      end
      if (f) pend.delete();
      if (xr) begin
        pend.push_back('{mem[0], edges});
        fifo_data_out = mem.pop_front();
      end else fifo_data_out = DW'($urandom);
    end
    if (w) begin
      mem.push_back(wd);
      wq.push_back(wd);
    end
    fifo_empty = mem.size() == 0;
  endtask
  task automatic clear_track();
    got.delete(); wq.delete();
    ren_cnt = 0; first_ren = -1; first_val = -1; last_pop = -1; gaps = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    pend.delete(); mem.delete(); beats = 0; fifo_empty = 1'b1;
    repeat (2) cycle(0, 0, 0, 0, '0);
    rst_n = 1'b1;
    clear_track();
  endtask
  task automatic load(input logic [DW-1:0] v);
    cycle(0, 0, 0, 1, v);
  endtask
  initial begin
    logic [DW-1:0] s4 [4];
    logic [DW-1:0] s5 [5];
    int written;
    s4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    s5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clear_track();
    #1 rst_n = 1'b0;
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst beat_count", beat_count, 0);
    chk("rst busy", busy, 0);
    chk("rst fifo_r_en", fifo_r_en, 0);
    do_reset();
    foreach (s4[i]) load(s4[i]);
    clear_track();
    repeat (10) cycle(1, 1, 0, 0, '0);
    chk("stream count", got.size(), 4);
    foreach (s4[i]) if (i < got.size()) chk("stream data", got[i], s4[i]);
    chk("stream latency", first_val - first_ren, 2);
    chk("stream gaps", gaps, 0);
    chk("stream beats", beat_count, 4);
    chk("stream busy", busy, 0);
    do_reset();
    foreach (s5[i]) load(s5[i]);
    clear_track();
    repeat (8) cycle(1, 0, 0, 0, '0);
    chk("bp r_en pulses", ren_cnt, 2);
    chk("bp m_valid", m_valid, 1);
    chk("bp m_data", m_data, 8'h11);
    repeat (12) cycle(1, 1, 0, 0, '0);
    chk("bp count", got.size(), 5);
    foreach (s5[i]) if (i < got.size()) chk("bp data", got[i], s5[i]);
    chk("bp beats", beat_count, 5);
    do_reset();
    repeat (20) cycle(1, 1, 0, 0, '0);
    chk("empty r_en pulses", ren_cnt, 0);
    cycle(1, 1, 0, 1, 8'hA5);
    repeat (6) cycle(1, 1, 0, 0, '0);
    chk("empty count", got.size(), 1);
    if (got.size() > 0) chk("empty data", got[0], 8'hA5);
    chk("empty beats", beat_count, 1);
    do_reset();
    load(8'h01); load(8'h02); load(8'h77);
    clear_track();
    repeat (2) cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 1, 0, '0);
    chk("flush m_valid", m_valid, 0);
    chk("flush busy", busy, 0);
    chk("flush beats", beat_count, 0);
    repeat (6) cycle(1, 1, 0, 0, '0);
    chk("flush count", got.size(), 1);
    if (got.size() > 0) chk("flush next data", got[0], 8'h77);
    do_reset();
    for (int i = 0; i < 6; i++) load(8'h81 + DW'(i));
    repeat (3) cycle(1, 1, 0, 0, '0);
    repeat (4) cycle(1, 0, 0, 0, '0);
    chk("pre-reset busy", busy, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async m_valid", m_valid, 0);
    chk("async busy", busy, 0);
    chk("async beat_count", beat_count, 0);
    chk("async fifo_r_en", fifo_r_en, 0);
    pend.delete();
    beats = 0;
    repeat (2) cycle(1, 1, 0, 0, '0);
    rst_n = 1'b1;
    repeat (10) cycle(1, 1, 0, 0, '0);
    chk("restart busy", busy, 0);
    do_reset();
    written = 0;
    for (int k = 0; k < 3000 && got.size() < 60; k++) begin
      logic w;
      w = written < 60 && 1'($urandom_range(0, 1));
      if (w) written++;
      cycle(1'(k % 2 == 0), 1'($urandom_range(0, 1)), 0, w, DW'($urandom));
    end
    chk("soak count", got.size(), 60);
    chk("soak beats", beat_count, 60);
    foreach (got[i]) if (i < wq.size()) chk("soak data", got[i], wq[i]);
    do_reset();
    repeat (300) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                       1'($urandom_range(0, 1)), DW'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
